tx_word_sched: RTL and testbench

Word-rate scheduler for the transmit tree serializer. Each divided-clock cycle it supplies the next `2**STAGES`-bit parallel word and a companion valid-lane word to the serializer. It sequences the link through idle, PRBS training, a framing marker and mission data, and applies backpressure to the upstream data source. It runs on the slowest serializer clock (the word clock), upstream of the `tree_ser` instance.

---
 rtl/tx_sched_pkg.sv | 39 +++
 rtl/prbs7_word_gen.sv | 49 ++++
 rtl/tx_word_sched.sv | 135 +++++++++++++
 tb/tb_tx_word_sched.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// Shared types, constants and the PRBS7 word-step helper for tx_word_sched.
package tx_sched_pkg;

  // Fixed state encoding, also exported on the debug/status port.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTrain = 2'd1,
    StMark  = 2'd2,
    StData  = 2'd3
  } sched_state_e;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  // Widest word supported (STAGES up to 6).
  localparam int unsigned MaxW = 64;

  // Framing marker at maximum width; users take the low W bits, which equals {W/8{8'hF0}}.
  localparam logic [MaxW-1:0] MARKER = {8{8'hF0}};

  // Advances the PRBS7 LFSR by w bits. Returns {next_state, word}; word bit i is the i-th
  // generated bit (bit 0 leaves the serializer first). Word bits at and above w are zero.
  function automatic logic [MaxW+6:0] prbs7_step_word(input logic [6:0] state_in,
                                                      input int unsigned w);
    logic [6:0]      s;
    logic [MaxW-1:0] word;
    logic            b;
    s    = state_in;
    word = '0;
    for (int i = 0; i < MaxW; i++) begin
      if (i < w) begin
        b       = s[6] ^ s[5];
        word[i] = b;
        s       = {s[5:0], b};
      end
    end
    return {s, word};
  endfunction

endpackage

// File: rtl/prbs7_word_gen.sv
// PRBS7 word generator: holds the LFSR and presents the next W-bit word combinationally.
module prbs7_word_gen
  import tx_sched_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         adv,
  output logic [W-1:0] word
);

  logic [6:0]      lfsr_q, lfsr_d;
  logic [MaxW+6:0] step;

  // Unrolled W-bit advance of the current LFSR state.
  always_comb begin
    step = prbs7_step_word(lfsr_q, W);
  end

  assign word = step[W-1:0];

  // Word bits above W are always zero; tie them off explicitly.
  if (W < MaxW) begin : g_unused_hi
    logic unused_word_hi;
    assign unused_word_hi = ^step[MaxW-1:W];
  end

  // Reseed has priority; otherwise advance only while words are being issued.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = PRBS7_SEED;
    end else if (adv) begin
      lfsr_d = step[MaxW+6:MaxW];
    end
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= PRBS7_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/tx_word_sched.sv
// Word-rate scheduler feeding the transmit tree serializer: idle, PRBS training, marker, data.
module tx_word_sched
  import tx_sched_pkg::*;
#(
  parameter  int unsigned STAGES      = 5,
  parameter  int unsigned TRAIN_WORDS = 64,
  localparam int unsigned W           = 2 ** STAGES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         train_req,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] ser_din,
  output logic [W-1:0] ser_valid,
  output logic [1:0]   state,
  output logic         train_done
);

  localparam int unsigned   CntW    = $clog2(TRAIN_WORDS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TRAIN_WORDS - 1);
  localparam logic [W-1:0]  MarkerW = MARKER[W-1:0];

  sched_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    ser_din_q, ser_din_d;
  logic [W-1:0]    ser_valid_q, ser_valid_d;
  logic            train_done_q, train_done_d;
  logic            train_entry;
  logic [W-1:0]    prbs_word;

  prbs7_word_gen #(
    .W(W)
  ) u_prbs (
    .clk  (clk),
    .rst  (rst),
    .load (train_entry),
    .adv  (state_q == StTrain),
    .word (prbs_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: en low wins over everything; train_req is ignored mid-burst.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (train_req) state_d = StTrain;
        StTrain: if (cnt_q == LastCnt) state_d = StMark;
        StMark:  state_d = StData;
        StData:  if (train_req) state_d = StTrain;
        default: state_d = StIdle;
      endcase
    end
  end

  assign train_entry = (state_d == StTrain) && (state_q != StTrain);

  // Training word counter: cleared on entry, counts issued words, holds elsewhere.
  always_comb begin
    cnt_d = cnt_q;
    if (train_entry) begin
      cnt_d = '0;
    end else if (state_q == StTrain) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Output words for the current state; the DATA word in flight always completes.
  always_comb begin
    ser_din_d    = '0;
    ser_valid_d  = '0;
    train_done_d = 1'b0;
    unique case (state_q)
      StIdle: ;
      StTrain: ser_din_d = prbs_word;
      StMark: begin
        // en low here cancels the burst, so no marker is issued.
        if (en) begin
          ser_din_d    = MarkerW;
          ser_valid_d  = '1;
          train_done_d = 1'b1;
        end
      end
      StData: begin
        if (in_valid) begin
          ser_din_d   = in_data;
          ser_valid_d = '1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_din_q    <= '0;
      ser_valid_q  <= '0;
      train_done_q <= 1'b0;
    end else begin
      ser_din_q    <= ser_din_d;
      ser_valid_q  <= ser_valid_d;
      train_done_q <= train_done_d;
    end
  end

  assign in_ready   = (state_q == StData);
  assign ser_din    = ser_din_q;
  assign ser_valid  = ser_valid_q;
  assign train_done = train_done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_tx_word_sched.sv
// Directed bench for tx_word_sched with STAGES=5, TRAIN_WORDS=4.
module tb_tx_word_sched;

  localparam int unsigned STAGES = 5;
  localparam int unsigned TW     = 4;
  localparam int unsigned W      = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         train_req;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] ser_din;
  logic [W-1:0] ser_valid;
  logic [1:0]   state;
  logic         train_done;

  int errors = 0;
  int checks = 0;

  logic [6:0]   ref_s;
  logic [W-1:0] exp_w;

  tx_word_sched #(
    .STAGES      (STAGES),
    .TRAIN_WORDS (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .train_req  (train_req),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_din    (ser_din),
    .ser_valid  (ser_valid),
    .state      (state),
    .train_done (train_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference PRBS7: one bit at a time from the bench's own LFSR copy.
  task automatic ref_next_word(output logic [W-1:0] w);
    logic b;
    for (int i = 0; i < W; i++) begin
      b     = ref_s[6] ^ ref_s[5];
      w[i]  = b;
      ref_s = {ref_s[5:0], b};
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; train_req = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ser_din", ser_din, 32'h0);
    chk("rst_ser_valid", ser_valid, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_train_done", 32'(train_done), 32'd0);

    // Enabled but no train request: stays idle.
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_ser_din", ser_din, 32'h0);
    end

    // Training burst from IDLE.
    train_req = 1'b1;
    tick();
    train_req = 1'b0;
    chk("train_enter_state", 32'(state), 32'd1);
    chk("train_enter_din", ser_din, 32'h0);
    chk("train_in_ready", 32'(in_ready), 32'd0);
    ref_s = 7'h7F;
    for (int k = 0; k < TW; k++) begin
      tick();
      ref_next_word(exp_w);
      if (k == 0) chk("prbs_first_low7", 32'(ser_din[6:0]), 32'b1000000);
      chk("prbs_word", ser_din, exp_w);
      chk("prbs_valid", ser_valid, 32'h0);
      chk("prbs_no_done", 32'(train_done), 32'd0);
    end
    chk("mark_state", 32'(state), 32'd2);
    tick();
    chk("marker_din", ser_din, 32'hF0F0F0F0);
    chk("marker_valid", ser_valid, 32'hFFFFFFFF);
    chk("marker_done", 32'(train_done), 32'd1);
    chk("data_state", 32'(state), 32'd3);
    chk("data_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("done_pulse_end", 32'(train_done), 32'd0);

    // Mission data with a gap on cycle 2.
    in_valid = 1'b1; in_data = 32'h00000001;
    tick();
    chk("data0", ser_din, 32'h00000001);
    chk("data0_valid", ser_valid, 32'hFFFFFFFF);
    in_data = 32'hDEADBEEF;
    tick();
    chk("data1", ser_din, 32'hDEADBEEF);
    in_valid = 1'b0; in_data = 32'hAAAA5555;
    tick();
    chk("gap_din", ser_din, 32'h0);
    chk("gap_valid", ser_valid, 32'h0);
    in_valid = 1'b1; in_data = 32'h12345678;
    tick();
    chk("data3", ser_din, 32'h12345678);
    chk("data3_valid", ser_valid, 32'hFFFFFFFF);

    // Retrain from DATA; the word in flight still completes.
    train_req = 1'b1; in_data = 32'hCAFEF00D;
    tick();
    train_req = 1'b0; in_valid = 1'b0;
    chk("retrain_inflight", ser_din, 32'hCAFEF00D);
    chk("retrain_state", 32'(state), 32'd1);
    chk("retrain_in_ready", 32'(in_ready), 32'd0);
    ref_s = 7'h7F;
    tick();
    ref_next_word(exp_w);
    chk("retrain_low7", 32'(ser_din[6:0]), 32'b1000000);
    chk("retrain_word0", ser_din, exp_w);

    // en drops during the 2nd training word, with train_req in the same cycle.
    en = 1'b0; train_req = 1'b1;
    tick();
    train_req = 1'b0;
    chk("cancel_state", 32'(state), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cancel_no_done", 32'(train_done), 32'd0);
      chk("cancel_no_valid", ser_valid, 32'h0);
    end

    // Back to DATA, then reset mid-transfer.
    en = 1'b1; train_req = 1'b1;
    tick();
    train_req = 1'b0;
    for (int i = 0; i < 20 && state != 2'd3; i++) tick();
    chk("reach_data", 32'(state), 32'd3);
    in_valid = 1'b1; in_data = 32'h55AA55AA; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_din", ser_din, 32'h0);
    chk("midrst_valid", ser_valid, 32'h0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
